// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   muldiv_op_t    : operation code presented on the request bus
//   muldiv_state_t : sequencer state (IDLE -> CALC -> FIXUP -> IDLE)
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    function automatic logic is_mul_op(muldiv_op_t op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic is_div_op(muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
//   master : core side (drives start/op/a/b/cancel, observes status and HI/LO)
//   slave  : unit side
interface mul_div_unit_if import mips_muldiv_pkg::*; #(
    parameter int WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_datapath.sv
// One iteration of the unsigned shift-add multiply or restoring divide.
//   is_div  : 1 = divide step, 0 = multiply step
//   acc     : upper half (partial product / partial remainder)
//   mq      : lower half (multiplier -> product low / dividend -> quotient)
//   opnd    : multiplicand or divisor (magnitude)
//   acc_nxt, mq_nxt : values after this step
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Multiply consumes the multiplier LSB-first and shifts the product right.
        sum    = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        // Divide shifts the next dividend bit into the partial remainder.
        rem_sh = {acc, mq[WIDTH-1]};
        // Only used when rem_sh >= opnd, so the result always fits WIDTH bits.
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_nxt = diff;
                mq_nxt  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = rem_sh[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated one bit per
// cycle in muldiv_datapath, then sign-corrected in a single FIXUP cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mul_div_unit_if.slave (start/op/a/b/cancel in,
//                busy/done/div_by_zero/hi/lo out)
module mul_div_unit import mips_muldiv_pkg::*; #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);
    muldiv_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mq, opnd;
    logic [WIDTH-1:0] acc_nxt, mq_nxt;
    logic             is_div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;

    logic             load, step, fix, wr_hi, wr_lo, dz_set;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .is_div  (is_div_q),
        .acc     (acc),
        .mq      (mq),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .mq_nxt  (mq_nxt)
    );

    // Magnitudes and signs of the incoming operands (signed ops only).
    always_comb begin
        sgn_a = is_signed_op(bus.op) & bus.a[WIDTH-1];
        sgn_b = is_signed_op(bus.op) & bus.b[WIDTH-1];
        abs_a = sgn_a ? -bus.a : bus.a;
        abs_b = sgn_b ? -bus.b : bus.b;
    end

    // Sign correction applied in FIXUP. Most-negative / -1 wraps back to
    // most-negative through the two's-complement negate, with no flag.
    always_comb begin
        prod_fix = neg_res_q ? -{acc, mq} : {acc, mq};
        quo_fix  = neg_res_q ? -mq : mq;
        rem_fix  = neg_rem_q ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        dz_set    = 1'b0;
        case (state)
            IDLE: begin
                // A flush in the same cycle drops the request entirely.
                if (bus.start && !bus.cancel) begin
                    if (is_mul_op(bus.op)) begin
                        load      = 1'b1;
                        state_nxt = CALC;
                    end else if (is_div_op(bus.op)) begin
                        if (bus.b == '0) begin
                            dz_set = 1'b1;
                        end else begin
                            load      = 1'b1;
                            state_nxt = CALC;
                        end
                    end else if (bus.op == MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.op == MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                state_nxt = IDLE;
                fix       = !bus.cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            mq        <= '0;
            opnd      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= fix | dz_set;
            dz_q   <= dz_set;
            if (load) begin
                cnt       <= CNT_W'(WIDTH);
                acc       <= '0;
                is_div_q  <= is_div_op(bus.op);
                // Divide: mq holds the dividend, opnd the divisor.
                // Multiply: mq holds the multiplier, opnd the multiplicand.
                mq        <= is_div_op(bus.op) ? abs_a : abs_b;
                opnd      <= is_div_op(bus.op) ? abs_b : abs_a;
                neg_res_q <= sgn_a ^ sgn_b;
                neg_rem_q <= sgn_a;
            end
            if (step) begin
                acc <= acc_nxt;
                mq  <= mq_nxt;
                cnt <= cnt - CNT_W'(1);
            end
            if (fix) begin
                if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
            if (wr_hi) hi_q <= bus.a;
            if (wr_lo) lo_q <= bus.a;
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
